// File: rtl/obstacle_scheduler_if.sv
// Bundle between the frame/game control side and the obstacle scheduler.
// The master drives the tick and game-state controls; the slave returns obstacle state.
interface obstacle_scheduler_if #(
    parameter int NUM_SLOTS = 3
);
    logic                   frame_tick;
    logic                   run;
    logic                   clear;
    logic [NUM_SLOTS-1:0]   obs_active;
    logic [10*NUM_SLOTS-1:0] obs_xpos;
    logic [4:0]             speed;
    logic                   spawn_pulse;
    logic                   passed_pulse;
    logic [15:0]            passed_count;

    modport master (
        output frame_tick, run, clear,
        input  obs_active, obs_xpos, speed, spawn_pulse, passed_pulse, passed_count
    );

    modport slave (
        input  frame_tick, run, clear,
        output obs_active, obs_xpos, speed, spawn_pulse, passed_pulse, passed_count
    );
endinterface

// File: rtl/obstacle_scheduler.sv
// Spawns, advances and retires runner-game obstacles once per frame tick,
// with LFSR-randomised spawn gaps and a saturating speed ramp.
module obstacle_scheduler #(
    parameter int          NUM_SLOTS     = 3,
    parameter int          X_SPAWN       = 800,
    parameter int          X_DESPAWN     = 150,
    parameter int          V_INIT        = 6,
    parameter int          V_MAX         = 15,
    parameter int          GAP_MIN       = 40,
    parameter int          GAP_MASK      = 63,
    parameter int          SPEEDUP_EVERY = 256,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    obstacle_scheduler_if.slave bus
);

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    logic [NUM_SLOTS-1:0] active_q, active_d;
    logic [9:0]           xpos_q [NUM_SLOTS];
    logic [9:0]           xpos_d [NUM_SLOTS];
    logic [4:0]           speed_q, speed_d;
    logic [15:0]          gapCnt_q, gapCnt_d;
    logic [15:0]          tickCnt_q, tickCnt_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic                 spawnPulse_q, spawnPulse_d;
    logic                 passedPulse_q, passedPulse_d;
    logic [15:0]          passedCount_q, passedCount_d;

    logic [10:0]          retireLimit;
    logic [2:0]           retiredCount;
    logic [16:0]          passedSum;
    logic                 slotFound;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q      <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) xpos_q[i] <= 10'(X_SPAWN);
            speed_q       <= 5'(V_INIT);
            gapCnt_q      <= 16'(GAP_MIN);
            tickCnt_q     <= '0;
            lfsr_q        <= LFSR_SEED;
            spawnPulse_q  <= 1'b0;
            passedPulse_q <= 1'b0;
            passedCount_q <= '0;
        end else begin
            active_q      <= active_d;
            for (int i = 0; i < NUM_SLOTS; i++) xpos_q[i] <= xpos_d[i];
            speed_q       <= speed_d;
            gapCnt_q      <= gapCnt_d;
            tickCnt_q     <= tickCnt_d;
            lfsr_q        <= lfsr_d;
            spawnPulse_q  <= spawnPulse_d;
            passedPulse_q <= passedPulse_d;
            passedCount_q <= passedCount_d;
        end
    end

    // Every decision below looks only at _q values, so retire, spawn, ramp and LFSR are order-free.
    always_comb begin
        active_d      = active_q;
        for (int i = 0; i < NUM_SLOTS; i++) xpos_d[i] = xpos_q[i];
        speed_d       = speed_q;
        gapCnt_d      = gapCnt_q;
        tickCnt_d     = tickCnt_q;
        lfsr_d        = lfsr_q;
        spawnPulse_d  = 1'b0;
        passedPulse_d = 1'b0;
        passedCount_d = passedCount_q;
        retireLimit   = 11'(X_DESPAWN) + {6'd0, speed_q};
        retiredCount  = '0;
        passedSum     = '0;
        slotFound     = 1'b0;

        if (bus.clear) begin
            active_d      = '0;
            for (int i = 0; i < NUM_SLOTS; i++) xpos_d[i] = 10'(X_SPAWN);
            speed_d       = 5'(V_INIT);
            gapCnt_d      = 16'(GAP_MIN);
            tickCnt_d     = '0;
            passedCount_d = '0;
        end else if (bus.frame_tick && bus.run) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (active_q[i]) begin
                    if ({1'b0, xpos_q[i]} < retireLimit) begin
                        active_d[i]  = 1'b0;
                        xpos_d[i]    = 10'(X_SPAWN);
                        retiredCount = retiredCount + 3'd1;
                    end else begin
                        xpos_d[i] = xpos_q[i] - {5'd0, speed_q};
                    end
                end
            end
            passedSum     = {1'b0, passedCount_q} + {14'd0, retiredCount};
            passedCount_d = passedSum[16] ? 16'hFFFF : passedSum[15:0];
            passedPulse_d = (retiredCount != 3'd0);

            // A blocked spawn leaves the gap at zero so it is retried on the next tick.
            if (gapCnt_q != 16'd0) begin
                gapCnt_d = gapCnt_q - 16'd1;
            end else begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (!slotFound && !active_q[i]) begin
                        slotFound   = 1'b1;
                        active_d[i] = 1'b1;
                        xpos_d[i]   = 10'(X_SPAWN);
                    end
                end
                if (slotFound) begin
                    gapCnt_d     = 16'(GAP_MIN) + {10'd0, lfsr_q[5:0] & 6'(GAP_MASK)};
                    spawnPulse_d = 1'b1;
                end
            end

            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

            if (tickCnt_q == 16'(SPEEDUP_EVERY - 1)) begin
                tickCnt_d = '0;
                if (speed_q < 5'(V_MAX)) speed_d = speed_q + 5'd1;
            end else begin
                tickCnt_d = tickCnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        bus.obs_xpos = '0;
        for (int i = 0; i < NUM_SLOTS; i++) bus.obs_xpos[10*i +: 10] = xpos_q[i];
    end

    assign bus.obs_active   = active_q;
    assign bus.speed        = speed_q;
    assign bus.spawn_pulse  = spawnPulse_q;
    assign bus.passed_pulse = passedPulse_q;
    assign bus.passed_count = passedCount_q;

endmodule
